// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_pkg
//  Description : Shared types and constants for the WS2812 serializer slice.
//                Pixel layout is GRB, green first on the wire.
//  Revision    : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

    localparam int BITS_PER_PIXEL = 24;
    localparam int BIT_PERIOD     = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

endpackage
`default_nettype wire

// File: rtl/ws2812_bit_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_bit_sync
//  Description : Bit-boundary detection and registered LED data output mux.
//                o_rise marks the first clk of every bit period (wave_one
//                rising). o_dout follows the selected waveform one clk later.
//  Ports       : clk, reset (sync, active-low)
//                i_wave_one / i_wave_zero : generator waveforms
//                i_drive   : 1 = output a waveform this cycle, 0 = force low
//                i_sel_bit : data bit choosing wave_one (1) or wave_zero (0)
//                o_rise    : combinational bit-period start strobe
//                o_dout    : registered LED data line
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_bit_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_wave_one,
    input  logic i_wave_zero,
    input  logic i_drive,
    input  logic i_sel_bit,
    output logic o_rise,
    output logic o_dout
);

    logic r_wave_one_d;
    logic r_dout;

    assign o_rise = i_wave_one & ~r_wave_one_d;
    assign o_dout = r_dout;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wave_one_d <= 1'b0;
            r_dout       <= 1'b0;
        end else begin
            r_wave_one_d <= i_wave_one;
            r_dout       <= i_drive & (i_sel_bit ? i_wave_one : i_wave_zero);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ws2812_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_serializer
//  Description : Shifts 24-bit GRB pixels MSB first onto a WS2812 data line,
//                NUM_LEDS pixels per frame, followed by a low latch gap of
//                LATCH_PERIODS bit periods and a frame_done pulse.
//  Ports       : clk, reset (sync, active-low)
//                i_wave_one / i_wave_zero : bit waveforms from the generator
//                i_pix_data / i_pix_valid / o_pix_ready : pixel handshake
//                o_dout       : registered LED data line
//                o_busy       : frame in progress (shift or latch)
//                o_frame_done : one-clk pulse at the end of the latch gap
//                o_underrun   : one-clk pulse when a mid-frame pixel is late
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_serializer
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS      = 8,
    parameter int LATCH_PERIODS = 40,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wave_one,
    input  logic        i_wave_zero,
    input  logic [23:0] i_pix_data,
    input  logic        i_pix_valid,
    output logic        o_pix_ready,
    output logic        o_dout,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_underrun
);

    localparam logic [4:0]       c_LAST_BIT   = 5'(BITS_PER_PIXEL - 1);
    localparam logic [CNT_W-1:0] c_LAST_LED   = CNT_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] c_LAST_LATCH = CNT_W'(LATCH_PERIODS - 1);

    state_t           r_state;
    logic [23:0]      r_shreg;
    logic [4:0]       r_bit_idx;
    logic [CNT_W-1:0] r_led_cnt;
    logic [CNT_W-1:0] r_latch_cnt;
    logic             r_busy;
    logic             r_frame_done;
    logic             r_underrun;

    pixel_t w_pix;
    logic   w_rise;
    logic   w_last_bit;
    logic   w_more_leds;
    logic   w_xfer;
    logic   w_sel_bit;
    logic   w_drive;

    assign w_pix       = i_pix_data;
    assign w_last_bit  = (r_bit_idx == c_LAST_BIT);
    assign w_more_leds = (r_led_cnt < c_LAST_LED);

    // Ready only exists on a bit boundary, so a waiting pixel is held until
    // the exact clk at which its first bit period begins.
    assign o_pix_ready = w_rise & ((r_state == ST_IDLE) |
                                   ((r_state == ST_SHIFT) & w_last_bit & w_more_leds));
    assign w_xfer      = o_pix_ready & i_pix_valid;

    // The bit shown on the line must already reflect the transition being
    // taken on this clk, otherwise the first clk of each period would carry
    // the previous bit.
    assign w_sel_bit = w_xfer                          ? w_pix.g[7]  :
                       (w_rise & (r_state == ST_SHIFT)) ? r_shreg[22] :
                                                          r_shreg[23];

    // Drive the waveform whenever the block will be shifting after this clk:
    // a transfer starts/continues a pixel, and the final rise of the last
    // bit (frame end or underrun) turns the line off immediately.
    assign w_drive = w_xfer | ((r_state == ST_SHIFT) & ~(w_rise & w_last_bit));

    ws2812_bit_sync u_bit_sync (
        .clk         (clk),
        .reset       (reset),
        .i_wave_one  (i_wave_one),
        .i_wave_zero (i_wave_zero),
        .i_drive     (w_drive),
        .i_sel_bit   (w_sel_bit),
        .o_rise      (w_rise),
        .o_dout      (o_dout)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bit_idx    <= '0;
            r_led_cnt    <= '0;
            r_latch_cnt  <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_shreg   <= w_pix;
                        r_bit_idx <= '0;
                        r_led_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_rise) begin
                        if (!w_last_bit) begin
                            r_shreg   <= {r_shreg[22:0], 1'b0};
                            r_bit_idx <= r_bit_idx + 5'd1;
                        end else if (w_xfer) begin
                            r_shreg   <= w_pix;
                            r_bit_idx <= '0;
                            r_led_cnt <= r_led_cnt + CNT_W'(1);
                        end else begin
                            // Either the frame is complete or the next pixel
                            // was not offered in time; both end in the gap.
                            r_underrun  <= w_more_leds;
                            r_latch_cnt <= '0;
                            r_state     <= ST_LATCH;
                        end
                    end
                end
                ST_LATCH: begin
                    if (w_rise) begin
                        if (r_latch_cnt == c_LAST_LATCH) begin
                            r_frame_done <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_latch_cnt <= r_latch_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812_serializer
//  Description : Scoreboard bench for ws2812_serializer. The driver pushes
//                expected pulse widths and frame events as pixels are
//                accepted; an independent monitor measures dout pulses and
//                status strobes and compares against those queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_serializer;

    localparam int NL = 3;
    localparam int LP = 6;
    localparam int CW = 8;
    localparam int BP = 14;

    typedef struct {
        bit under;
        int xfers;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wave_one;
    logic        wave_zero;
    logic [23:0] i_pix_data = '0;
    logic        i_pix_valid = 1'b0;
    logic        o_pix_ready;
    logic        o_dout;
    logic        o_busy;
    logic        o_frame_done;
    logic        o_underrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit  q_bits[$];
    ev_t q_ev[$];

    logic [23:0] frame_px [NL];

    bit m_prev = 1'b0;
    int m_start = 0;
    int m_hs = 0;
    bit m_seen_under = 1'b0;
    int frames_done = 0;

    // Bit waveform generator: 14-clk periods, "1" high 8 clk, "0" high 4 clk.
    logic [3:0] r_gcnt;
    always @(posedge clk) begin
        if (!reset) r_gcnt <= 4'd0;
        else        r_gcnt <= (r_gcnt == 4'd13) ? 4'd0 : r_gcnt + 4'd1;
    end
    assign wave_one  = (r_gcnt < 4'd8);
    assign wave_zero = (r_gcnt < 4'd4);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2812_serializer #(
        .NUM_LEDS      (NL),
        .LATCH_PERIODS (LP),
        .CNT_W         (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_wave_one   (wave_one),
        .i_wave_zero  (wave_zero),
        .i_pix_data   (i_pix_data),
        .i_pix_valid  (i_pix_valid),
        .o_pix_ready  (o_pix_ready),
        .o_dout       (o_dout),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_underrun   (o_underrun)
    );

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: samples on the falling edge, away from the DUT update edge.
    always @(negedge clk) begin
        if (!reset) begin
            m_prev       = 1'b0;
            m_hs         = 0;
            m_seen_under = 1'b0;
        end else begin
            if (o_pix_ready) chk("ready_on_rise", int'(r_gcnt), 0);
            if (o_pix_ready && i_pix_valid) m_hs++;
            if (o_dout && !m_prev) begin
                // generator advanced once since the rise clk: 1 clk latency
                chk("dout_rise_align", int'(r_gcnt), 1);
                chk("busy_in_pulse", int'(o_busy), 1);
                m_start = cyc;
            end
            if (!o_dout && m_prev) begin
                if (q_bits.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    bit b;
                    b = q_bits.pop_front();
                    chk("pulse_width", cyc - m_start, b ? 8 : 4);
                end
            end
            if (o_underrun) begin
                if (q_ev.size() == 0) chk("underrun_unexpected", 1, 0);
                else                  chk("underrun_expected", int'(q_ev[0].under), 1);
                chk("underrun_time", cyc - m_start, BP);
                m_seen_under = 1'b1;
            end
            if (o_frame_done) begin
                if (q_ev.size() == 0) begin
                    chk("frame_done_unexpected", 1, 0);
                end else begin
                    ev_t e;
                    e = q_ev.pop_front();
                    chk("underrun_seen", int'(m_seen_under), int'(e.under));
                    chk("transfers", m_hs, e.xfers);
                end
                chk("frame_done_time", cyc - m_start, BP * (LP + 1));
                chk("busy_at_done", int'(o_busy), 0);
                chk("bits_left_at_done", q_bits.size(), 0);
                m_hs         = 0;
                m_seen_under = 1'b0;
                frames_done++;
            end
            m_prev = o_dout;
        end
    end

    task automatic idle_for(input int n);
        i_pix_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            i_pix_data = 24'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pixel(input logic [23:0] p);
        bit ok;
        ok = 1'b0;
        i_pix_data  = p;
        i_pix_valid = 1'b1;
        for (int t = 0; t < 800; t++) begin
            @(negedge clk);
            if (o_pix_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            for (int i = 23; i >= 0; i--) q_bits.push_back(p[i]);
        end else begin
            chk("ready_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        i_pix_valid = 1'b0;
        i_pix_data  = 24'($urandom);
    endtask

    task automatic run_frame(input int n_send);
        ev_t e;
        int  target;
        e.under = (n_send < NL);
        e.xfers = n_send;
        target  = frames_done + 1;
        for (int i = 0; i < n_send; i++) begin
            idle_for((i == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 150)));
            send_pixel(frame_px[i]);
            if (i == n_send - 1) q_ev.push_back(e);
        end
        for (int t = 0; t < (BITS_PER_FRAME_BOUND() + LP + 4) * BP; t++) begin
            if (frames_done >= target) break;
            @(negedge clk);
        end
        chk("frame_timeout", int'(frames_done >= target), 1);
    endtask

    function automatic int BITS_PER_FRAME_BOUND();
        return 24 * 2;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset: everything quiet.
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dout", int'(o_dout), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_frame_done", int'(o_frame_done), 0);
        chk("rst_underrun", int'(o_underrun), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Idle with no valid: ready pulses exactly on rise clks, line low.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("idle_ready", int'(o_pix_ready), int'(r_gcnt == 4'd0));
            chk("idle_dout", int'(o_dout), 0);
            chk("idle_busy", int'(o_busy), 0);
        end
        @(posedge clk);
        #1;

        // Directed full frames: solid green, MSB/LSB markers, alternating.
        frame_px[0] = 24'hFF0000;
        frame_px[1] = 24'h800001;
        frame_px[2] = 24'hAAAAAA;
        run_frame(NL);
        frame_px[0] = 24'h555555;
        frame_px[1] = 24'hAAAAAA;
        frame_px[2] = 24'h555555;
        run_frame(NL);

        // Underruns after pixel 0 and after pixel 1.
        frame_px[0] = 24'($urandom);
        run_frame(1);
        frame_px[0] = 24'($urandom);
        frame_px[1] = 24'($urandom);
        run_frame(2);

        // Random frames with random truncation.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NL; i++) frame_px[i] = 24'($urandom);
            run_frame(int'($urandom_range(1, NL)));
        end

        // Reset in the middle of pixel 0.
        frame_px[0] = 24'($urandom);
        send_pixel(frame_px[0]);
        repeat ($urandom_range(20, 60)) @(posedge clk);
        #1;
        reset = 1'b0;
        q_bits.delete();
        q_ev.delete();
        @(posedge clk);
        #1;
        chk("midrst_dout", int'(o_dout), 0);
        chk("midrst_busy", int'(o_busy), 0);
        chk("midrst_frame_done", int'(o_frame_done), 0);
        chk("midrst_underrun", int'(o_underrun), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Restart after reset: a fresh full frame from bit 23.
        for (int i = 0; i < NL; i++) frame_px[i] = 24'($urandom);
        run_frame(NL);

        repeat (5) @(negedge clk);
        chk("leftover_bits", q_bits.size(), 0);
        chk("leftover_events", q_ev.size(), 0);
        chk("final_busy", int'(o_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ws2812_serializer.md
Name: ws2812_serializer

Overview:
- Downstream consumer of the bit-waveform generator, which produces wave_one (high 8 of every 14 clk) and wave_zero (high 4 of every 14 clk).
- Accepts 24-bit GRB pixels over a valid/ready handshake and shifts them out MSB first on a single LED data line.
- For each bit period it selects wave_one for a 1 and wave_zero for a 0.
- After NUM_LEDS pixels it holds the line low for a latch gap, then pulses frame_done.

Parameters:
- NUM_LEDS, 8: pixels per frame (≥1).
- LATCH_PERIODS, 40: number of low bit periods (14 clk each) forming the latch/reset gap.
- CNT_W, 8: width of the LED and latch counters; must hold max(NUM_LEDS, LATCH_PERIODS).

Ports:
- clk  in  1  system clock; same clock as the waveform generator.
- reset  in  1  synchronous, active-low.
- wave_one  in  1  "1"-bit waveform from the generator.
- wave_zero  in  1  "0"-bit waveform from the generator.
- pix_data  in  24  pixel, [23:16]=G, [15:8]=R, [7:0]=B.
- pix_valid  in  1  pix_data valid.
- pix_ready  out  1  combinational; transfer occurs when pix_valid & pix_ready.
- dout  out  1  registered LED data line.
- busy  out  1  high in SHIFT or LATCH.
- frame_done  out  1  one-cycle pulse at end of latch gap.
- underrun  out  1  one-cycle pulse when a mid-frame pixel is missing.

Behaviour:
- Reset is sampled on clk; reset=0 for ≥1 cycle forces:
  - state=IDLE, shift register=0, bit_idx=0, led_cnt=0, latch_cnt=0, wave_one_d=0.
  - dout=0, busy=0, frame_done=0, underrun=0.
- Reset mid-frame aborts the frame with no further output. The bench keeps the generator and this block in reset together.
- Bit boundary: rise = wave_one & ~wave_one_d, where wave_one_d is wave_one registered. One rise occurs every 14 clk.
- pix_ready = rise & (state==IDLE | (state==SHIFT & bit_idx==23 & led_cnt<NUM_LEDS-1)).
- sel_bit:
  - If a transfer occurs this cycle: pix_data[23].
  - Else if rise in SHIFT: shift register's next bit.
  - Else: current bit.
- Output:
  - SHIFT: dout <= sel_bit ? wave_one : wave_zero.
  - IDLE/LATCH: dout <= 0.
  - Latency is exactly 1 clk from the wave inputs to dout.
- IDLE:
  - On rise with pix_valid: load pixel, bit_idx=0, led_cnt=0, go to SHIFT.
  - Otherwise stay in IDLE with dout low.
- SHIFT, on each rise:
  - bit_idx<23: shift left, bit_idx++.
  - bit_idx==23 & led_cnt<NUM_LEDS-1:
    - With transfer: load new pixel, bit_idx=0, led_cnt++.
    - Without transfer: underrun pulse, go to LATCH (frame truncated).
  - bit_idx==23 & led_cnt==NUM_LEDS-1: go to LATCH, latch_cnt=0.
- LATCH:
  - Count rises; dout=0.
  - On the rise where latch_cnt==LATCH_PERIODS-1: frame_done pulse that cycle, go to IDLE.
  - A new frame can start no earlier than the following rise.
- pix_valid may drop without a transfer; pix_data is only sampled on a transfer.
- pix_valid held while not ready: pixel is held and no ready is generated outside rise cycles.
- Frame timing: a full frame is NUM_LEDS*24 bit periods plus LATCH_PERIODS periods (default 232*14 clk in active+latch).
- Counters never wrap: bit_idx is 5 bits, saturating at 23 only via the state change. led_cnt and latch_cnt are CNT_W bits.

Decomposition:
- Shared package ws2812_pkg:
  - BITS_PER_PIXEL=24, BIT_PERIOD=14.
  - State enum {IDLE, SHIFT, LATCH}.
  - Pixel typedef, a 24-bit struct g/r/b.
- Natural sub-module: ws2812_bit_sync. It holds the wave_one_d register, rise detect, and the registered output mux. Frame FSM and counters stay in the top.

Test Plan:
- Reset low 3 cycles, then high with pix_valid=0 → dout=0, busy=0, pix_ready pulses only on rise cycles, no transfer.
- NUM_LEDS=1, pixel 0xFF0000 → 8 bit periods with dout high 8 clk then low 6, then 16 periods high 4 clk, then 40*14 clk low, then frame_done pulse.
- Pixel 0x800001 → bit 23 long pulse, bits 22..1 short, bit 0 long; each dout rising edge exactly 1 clk after a wave_one rise.
- NUM_LEDS=2, pixels 0xAAAAAA then 0x555555 held valid → alternating long/short pulses; exactly 2 transfers; 48 contiguous periods with no gap before LATCH.
- NUM_LEDS=3, second pixel withheld → underrun pulse at the end of pixel 1, latch gap follows, frame_done, busy drops.
- Reset asserted mid-bit of pixel 0 → dout=0 on the next clk, state IDLE, and a new pixel after release restarts at bit 23.
